// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  // Advance an index by one and wrap to zero at n; works for any n, not only powers of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: reports the index of the winning set bit and whether any bit is set.
// HIGH_INDEX_PRIORITY=0 picks the lowest set index, 1 picks the highest.
module priority_encoder #(
  parameter int unsigned WIDTH               = 4,
  parameter bit          HIGH_INDEX_PRIORITY = 1'b0,
  localparam int unsigned IDX_W              = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan so that the preferred bit is visited last and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    idx = '0;
    any = |vec;
    if (HIGH_INDEX_PRIORITY) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered valid/ready grant output.
// The most recently served requester drops to lowest priority after each handshake.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [$clog2(NUM_REQ)-1:0] gnt_addr_o,
  output logic [NUM_REQ-1:0]         gnt_onehot_o,
  output logic                       gnt_valid_o,
  input  logic                       gnt_ready_i
);

  localparam int unsigned ADDR_W = $clog2(NUM_REQ);

  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  addr_q;
  logic               valid_q;

  logic               handshake;
  logic               load;
  logic [ADDR_W-1:0]  next_ptr;
  logic [ADDR_W-1:0]  ptr_eff;
  logic [NUM_REQ-1:0] masked;
  logic [ADDR_W-1:0]  masked_idx;
  logic               masked_any;
  logic [ADDR_W-1:0]  raw_idx;
  logic               raw_any;
  logic [ADDR_W-1:0]  sel;

  assign handshake = valid_q & gnt_ready_i;
  // The register may load when it is empty or is being drained this cycle.
  assign load      = ~valid_q | gnt_ready_i;
  assign next_ptr  = ADDR_W'(wrap_inc(32'(addr_q), NUM_REQ));
  // Look ahead past the grant being accepted now, so back-to-back grants rotate correctly.
  assign ptr_eff   = handshake ? next_ptr : ptr;

  // Keep only the requests at or above the rotating pointer.
  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      masked[i] = req_i[i] & (ADDR_W'(i) >= ptr_eff);
    end
  end

  priority_encoder #(
    .WIDTH               (NUM_REQ),
    .HIGH_INDEX_PRIORITY (1'b0)
  ) u_masked_enc (
    .vec (masked),
    .idx (masked_idx),
    .any (masked_any)
  );

  priority_encoder #(
    .WIDTH               (NUM_REQ),
    .HIGH_INDEX_PRIORITY (1'b0)
  ) u_raw_enc (
    .vec (req_i),
    .idx (raw_idx),
    .any (raw_any)
  );

  // With nothing at or above the pointer, wrap around to the lowest active request.
  assign sel = masked_any ? masked_idx : raw_idx;

  // Grant and pointer registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      ptr     <= '0;
    end else begin
      if (handshake) ptr <= next_ptr;
      if (load) begin
        valid_q <= raw_any;
        if (raw_any) addr_q <= sel;
      end
    end
  end

  // One-hot view decoded only from registered state, so inputs never reach the outputs.
  always_comb begin
    gnt_onehot_o = '0;
    if (valid_q) gnt_onehot_o[addr_q] = 1'b1;
  end

  assign gnt_addr_o  = addr_q;
  assign gnt_valid_o = valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (NUM_REQ=4): directed scenarios plus a random stream,
// each observation compared against a scoreboard fed by an independent round-robin model.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic          gnt_ready_i = 1'b0;
  logic [AW-1:0] gnt_addr_o;
  logic [N-1:0]  gnt_onehot_o;
  logic          gnt_valid_o;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [N-1:0]  onehot;
  } grant_t;

  typedef struct packed {
    logic          rst;
    logic [N-1:0]  req;
    logic          rdy;
    logic          v;
    logic [AW-1:0] a;
    logic [N-1:0]  oh;
  } step_t;

  grant_t sb[$];
  int     total  = 0;
  int     passed = 0;

  // Reference model state
  bit m_valid = 1'b0;
  int m_addr  = 0;
  int m_ptr   = 0;

  rr_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_addr_o   (gnt_addr_o),
    .gnt_onehot_o (gnt_onehot_o),
    .gnt_valid_o  (gnt_valid_o),
    .gnt_ready_i  (gnt_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus, push the model's post-edge prediction, and land 1 ns after the edge.
  task automatic cycle(input logic [N-1:0] req, input logic ready, input logic rst);
    grant_t e;
    bit     hs;
    bit     found;
    int     start;
    int     pick;
    @(negedge clk_i);
    req_i       = req;
    gnt_ready_i = ready;
    rst_i       = rst;
    if (rst) begin
      m_valid = 1'b0;
      m_addr  = 0;
      m_ptr   = 0;
    end else begin
      hs    = m_valid && ready;
      start = hs ? (m_addr + 1) % N : m_ptr;
      if (hs) m_ptr = start;
      if (!m_valid || ready) begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (start + k) % N;
          if (!found && req[j]) begin
            found = 1'b1;
            pick  = j;
          end
        end
        m_valid = found;
        if (found) m_addr = pick;
      end
    end
    e.valid  = m_valid;
    e.addr   = AW'(m_addr);
    e.onehot = m_valid ? (N'(1) << m_addr) : '0;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    step_t  t [3];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL reset[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL reset[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_rotation();
    step_t  t [8];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL rotation[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL rotation[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    step_t  t [7];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL backpressure[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL backpressure[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_request_drop();
    step_t  t [6];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001},
          '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL drop[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL drop[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_single();
    step_t  t [6];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL single[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL single[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    step_t  t [7];
    grant_t e;
    grant_t got;
    t = '{'{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100},
          '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001},
          '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010}};
    foreach (t[i]) begin
      cycle(t[i].req, t[i].rdy, t[i].rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL mid_reset[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
      total++;
      if (got !== {t[i].v, t[i].a, t[i].oh})
        $display("FAIL mid_reset[%0d] plan: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                 i, got.valid, got.addr, got.onehot, t[i].v, t[i].a, t[i].oh);
      else passed++;
    end
  endtask

  task automatic test_random();
    grant_t       e;
    grant_t       got;
    logic [N-1:0] req;
    logic         rdy;
    logic         rst;
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle(req, rdy, rst);
      e   = sb.pop_front();
      got = {gnt_valid_o, gnt_addr_o, gnt_onehot_o};
      total++;
      if (got !== e) $display("FAIL random[%0d] model: got v=%b a=%0d oh=%b, expected v=%b a=%0d oh=%b",
                              i, got.valid, got.addr, got.onehot, e.valid, e.addr, e.onehot);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_request_drop();
    test_single();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of a requester-indexed consumer and is built on the existing LSB-priority `priority_encoder`.
- Takes a request vector and issues one registered grant (index plus one-hot) per valid/ready handshake.
- Rotates priority so the most recently served requester becomes lowest priority.
- Used wherever N sources share one sink: bus masters, FIFO drain ports, and similar.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  request vector; bit i set = requester i wants service.
- gnt_addr_o  output  $clog2(NUM_REQ)  index of the granted requester (registered).
- gnt_onehot_o  output  NUM_REQ  one-hot form of gnt_addr_o; all zero when gnt_valid_o=0.
- gnt_valid_o  output  1  a grant is presented.
- gnt_ready_i  input  1  downstream accepts the grant; handshake = gnt_valid_o & gnt_ready_i.

Behaviour:
- Reset (rst_i=1 at an edge): gnt_valid_o=0, gnt_addr_o=0, gnt_onehot_o=0, internal pointer ptr=0. Reset overrides every other event, including a handshake in the same cycle.
- Internal state:
  - ptr, $clog2(NUM_REQ) bits: lowest index currently holding top priority.
  - Grant register: addr, valid.
- Load condition: load = ~gnt_valid_o | gnt_ready_i (output empty, or emptying this cycle).
- Effective pointer: ptr_eff = (handshake) ? wrap(gnt_addr_o+1) : ptr.
  - wrap(x) = 0 when x == NUM_REQ, otherwise x. This also covers non-power-of-two NUM_REQ.
- Selection:
  - masked = req_i & {bits with index >= ptr_eff}.
  - If masked is nonzero: choose the lowest set index of masked.
  - Otherwise: choose the lowest set index of req_i.
  - Implemented with two LSB-priority encoders plus a mux.
- On an edge with load=1:
  - If req_i is nonzero: gnt_valid_o←1, gnt_addr_o←selection.
  - Else: gnt_valid_o←0; gnt_addr_o holds its old value (don't-care while invalid).
- On an edge with load=0 (gnt_valid_o=1 and gnt_ready_i=0): the grant is held. addr, onehot and valid stay stable even if req_i changes, including deassertion of the granted bit.
- ptr update: ptr←wrap(gnt_addr_o+1) only on a handshake; otherwise it holds.
- Latency: a request seen at edge k appears as gnt_valid_o after edge k (1 cycle). With gnt_ready_i tied high, back-to-back grants are issued every cycle (throughput 1).
- Fairness: with all requesters continuously asserting, each is granted exactly once per NUM_REQ handshakes.
- Single requester: it is granted on every handshake; ptr moves past it and wraps back.
- req_i=0 while gnt_ready_i=1: gnt_valid_o drops to 0 next cycle.
- Output ordering: gnt_onehot_o is decoded from the registered addr/valid. No combinational path from req_i or gnt_ready_i to any output.

Decomposition:
- No shared package typedefs are required.
- ADDR_W = $clog2(NUM_REQ) is a localparam.
- Reuse the existing `priority_encoder` (HIGH_INDEX_PRIORITY=0) twice, for the masked and unmasked paths. No new sub-module.
- Mask generation, wrap, and the grant/pointer registers stay in rr_arbiter.

Test Plan (NUM_REQ=4):
- Reset, then req_i=4'b1111 with gnt_ready_i=1 held → gnt_addr_o sequence 0,1,2,3,0,1 on consecutive cycles; gnt_valid_o rises 1 cycle after req assertion; gnt_onehot_o 0001,0010,0100,1000.
- req_i=4'b0110, gnt_ready_i=0 for 3 cycles, then 1 → addr=1 held stable for 3 cycles; on the handshake the next grant is addr=2; after that handshake ptr=3 and the next grant is 1 (wrap).
- Backpressure with request drop: grant addr=2 pending with ready=0, then req_i→4'b0001 → addr stays 2 and valid stays 1 until ready; then addr=0.
- Single requester req_i=4'b0100, ready=1 → addr=2 every cycle, valid continuously 1; req_i→0 → valid=0 the following cycle.
- Mid-operation reset: req_i=1111 streaming, assert rst_i at an edge where a handshake occurs → next cycle valid=0, addr=0, ptr=0; after release the first grant is addr=0.
